// File: rtl/counter_time_prog.sv
`default_nettype none
// ============================================================================
// Module      : counter_time_prog
// Description : Round/response timer for the game core. Counts TEMPO up to a
//               programmable LIMIT at a prescaled rate, in one-shot or
//               periodic mode, with pause, synchronous restart, a sticky
//               expiry flag and a near-timeout warning.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_time_prog #(
    parameter int SIZE      = 4,
    parameter int PRESC_W   = 8,
    parameter int WARN_LEFT = 2
) (
    input  logic               CLKT,
    input  logic               R,
    input  logic               E,
    input  logic               CLR,
    input  logic               MODE,
    input  logic [PRESC_W-1:0] DIV,
    input  logic [SIZE-1:0]    LIMIT,
    output logic [SIZE-1:0]    TEMPO,
    output logic               end_time,
    output logic               expired,
    output logic               warn,
    output logic               tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [SIZE:0] c_WARN_LEFT = (SIZE+1)'(WARN_LEFT);

    state_t             r_state;
    logic [PRESC_W-1:0] r_presc;
    logic [SIZE:0]      w_warn_sum;
    logic               w_active;

    // Near-timeout warning: one extra bit on the sum so it never wraps.
    assign w_warn_sum = {1'b0, TEMPO} + c_WARN_LEFT;
    assign w_active   = (r_state == S_RUN) || (r_state == S_HOLD);
    assign warn       = w_active && (w_warn_sum >= {1'b0, LIMIT});

    // Timer FSM: restart beats everything, pulses default low each cycle.
    always_ff @(posedge CLKT or negedge R) begin
        if (!R) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            TEMPO    <= '0;
            end_time <= 1'b0;
            expired  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            end_time <= 1'b0;
            tick     <= 1'b0;
            if (CLR) begin
                r_state <= S_IDLE;
                r_presc <= '0;
                TEMPO   <= '0;
                expired <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        TEMPO <= '0;
                        if (E) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (!E) begin
                            r_state <= S_HOLD;
                        end else if (r_presc != DIV) begin
                            r_presc <= r_presc + PRESC_W'(1);
                        end else begin
                            r_presc <= '0;
                            tick    <= 1'b1;
                            // Compare against the live LIMIT so lowering it
                            // mid-count terminates instead of wrapping.
                            if (TEMPO >= LIMIT) begin
                                end_time <= 1'b1;
                                if (MODE) begin
                                    TEMPO <= '0;
                                end else begin
                                    expired <= 1'b1;
                                    r_state <= S_DONE;
                                end
                            end else begin
                                TEMPO <= TEMPO + SIZE'(1);
                            end
                        end
                    end
                    S_HOLD: begin
                        if (E) begin
                            r_state <= S_RUN;
                        end
                    end
                    S_DONE: begin
                        expired <= 1'b1;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_time_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_time_prog
// Description : Scoreboard bench for counter_time_prog. The stimulus process
//               queues the expected outputs of each tick; a monitor pops and
//               compares whenever the DUT pulses tick.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_time_prog;

    localparam int c_SIZE    = 4;
    localparam int c_PRESC_W = 8;

    typedef struct {
        int tempo;
        int end_t;
        int expd;
        int wrn;
    } exp_t;

    logic                 CLKT;
    logic                 R;
    logic                 E;
    logic                 CLR;
    logic                 MODE;
    logic [c_PRESC_W-1:0] DIV;
    logic [c_SIZE-1:0]    LIMIT;
    logic [c_SIZE-1:0]    TEMPO;
    logic                 end_time;
    logic                 expired;
    logic                 warn;
    logic                 tick;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;

    counter_time_prog #(
        .SIZE      (c_SIZE),
        .PRESC_W   (c_PRESC_W),
        .WARN_LEFT (2)
    ) u_dut (
        .CLKT     (CLKT),
        .R        (R),
        .E        (E),
        .CLR      (CLR),
        .MODE     (MODE),
        .DIV      (DIV),
        .LIMIT    (LIMIT),
        .TEMPO    (TEMPO),
        .end_time (end_time),
        .expired  (expired),
        .warn     (warn),
        .tick     (tick)
    );

    initial CLKT = 1'b0;
    always #5 CLKT = ~CLKT;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int t, input int e, input int x, input int w);
        exp_t it;
        it.tempo = t;
        it.end_t = e;
        it.expd  = x;
        it.wrn   = w;
        sb.push_back(it);
    endtask

    // Advance n cycles, landing just after the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge CLKT);
        #1;
    endtask

    task automatic do_clr();
        CLR = 1'b1;
        E   = 1'b0;
        step(1);
        CLR = 1'b0;
    endtask

    // Monitor: every tick pulse must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge CLKT);
            if (tick === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_tick", 32'd1, 32'd0);
                end else begin
                    exp_t it;
                    it = sb.pop_front();
                    chk("sb_tempo",    32'(TEMPO),    32'(it.tempo));
                    chk("sb_end_time", 32'(end_time), 32'(it.end_t));
                    chk("sb_expired",  32'(expired),  32'(it.expd));
                    chk("sb_warn",     32'(warn),     32'(it.wrn));
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        R     = 1'b0;
        E     = 1'b0;
        CLR   = 1'b0;
        MODE  = 1'b1;
        DIV   = '0;
        LIMIT = '0;

        // Reset state
        #12;
        chk("rst_tempo",   32'(TEMPO),    32'd0);
        chk("rst_end",     32'(end_time), 32'd0);
        chk("rst_expired", 32'(expired),  32'd0);
        chk("rst_tick",    32'(tick),     32'd0);
        chk("rst_warn",    32'(warn),     32'd0);
        R = 1'b1;
        step(2);
        chk("idle_warn", 32'(warn), 32'd0);

        // Legacy equivalence: DIV=0, LIMIT=9, periodic, two full periods
        DIV = 8'd0; LIMIT = 4'd9; MODE = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int k = 1; k <= 9; k++) push(k, 0, 0, (k >= 7) ? 1 : 0);
            push(0, 1, 0, 0);
        end
        E = 1'b1;
        step(21);
        chk("legacy_drain", 32'(sb.size()), 32'd0);
        do_clr();

        // Prescale + one-shot: DIV=3, LIMIT=2
        DIV = 8'd3; LIMIT = 4'd2; MODE = 1'b0;
        push(1, 0, 0, 1);
        push(2, 0, 0, 1);
        push(2, 1, 1, 0);
        E = 1'b1;
        step(13);
        chk("oneshot_drain",   32'(sb.size()), 32'd0);
        chk("oneshot_expired", 32'(expired),   32'd1);
        chk("oneshot_tempo",   32'(TEMPO),     32'd2);
        step(10);
        chk("done_tempo",   32'(TEMPO),    32'd2);
        chk("done_expired", 32'(expired),  32'd1);
        chk("done_end",     32'(end_time), 32'd0);
        chk("done_warn",    32'(warn),     32'd0);
        // Restart out of DONE, E kept high
        CLR = 1'b1;
        step(1);
        chk("clrdone_tempo",   32'(TEMPO),   32'd0);
        chk("clrdone_expired", 32'(expired), 32'd0);
        chk("clrdone_warn",    32'(warn),    32'd0);
        CLR = 1'b0;
        step(1);
        chk("clrdone_rerun_warn", 32'(warn), 32'd1);
        do_clr();

        // Pause/resume: DIV=2, LIMIT=9, periodic
        DIV = 8'd2; LIMIT = 4'd9; MODE = 1'b1;
        for (int k = 1; k <= 4; k++) push(k, 0, 0, 0);
        E = 1'b1;
        step(14);
        chk("pause_pre_drain", 32'(sb.size()), 32'd0);
        E = 1'b0;
        LIMIT = 4'd6;
        step(5);
        chk("hold_tempo", 32'(TEMPO), 32'd4);
        chk("hold_warn",  32'(warn),  32'd1);
        chk("hold_tick",  32'(tick),  32'd0);
        push(5, 0, 0, 1);
        E = 1'b1;
        step(2);
        chk("resume_wait", 32'(sb.size()), 32'd1);
        step(1);
        chk("resume_drain", 32'(sb.size()), 32'd0);
        do_clr();

        // Restart priority in RUN at TEMPO=6 with E=1
        DIV = 8'd0; LIMIT = 4'd9;
        for (int k = 1; k <= 6; k++) push(k, 0, 0, 0);
        E = 1'b1;
        step(7);
        chk("run6_tempo", 32'(TEMPO), 32'd6);
        CLR = 1'b1;
        step(1);
        chk("clrrun_tempo",   32'(TEMPO),   32'd0);
        chk("clrrun_expired", 32'(expired), 32'd0);
        chk("clrrun_tick",    32'(tick),    32'd0);
        CLR = 1'b0;
        push(1, 0, 0, 0);
        step(1);
        chk("clrrun_entry_tempo", 32'(TEMPO),     32'd0);
        chk("clrrun_entry_wait",  32'(sb.size()), 32'd1);
        step(1);
        chk("clrrun_drain", 32'(sb.size()), 32'd0);
        do_clr();

        // LIMIT=0 periodic: end_time on every tick
        DIV = 8'd0; LIMIT = 4'd0; MODE = 1'b1;
        for (int k = 0; k < 5; k++) push(0, 1, 0, 1);
        E = 1'b1;
        step(1);
        chk("lim0_entry_end", 32'(end_time), 32'd0);
        step(5);
        chk("lim0_drain", 32'(sb.size()), 32'd0);
        do_clr();

        // Live LIMIT drop 9 -> 3 at TEMPO=7
        LIMIT = 4'd9;
        for (int k = 1; k <= 7; k++) push(k, 0, 0, (k >= 7) ? 1 : 0);
        E = 1'b1;
        step(8);
        chk("limdrop_tempo", 32'(TEMPO), 32'd7);
        LIMIT = 4'd3;
        push(0, 1, 0, 0);
        push(1, 0, 0, 1);
        step(2);
        chk("limdrop_drain", 32'(sb.size()), 32'd0);

        // Asynchronous reset between edges
        #2;
        R = 1'b0;
        #1;
        chk("arst_tempo",   32'(TEMPO),    32'd0);
        chk("arst_end",     32'(end_time), 32'd0);
        chk("arst_expired", 32'(expired),  32'd0);
        chk("arst_tick",    32'(tick),     32'd0);
        chk("arst_warn",    32'(warn),     32'd0);
        step(2);
        E = 1'b0;
        LIMIT = 4'd0;
        R = 1'b1;
        step(3);
        chk("arst_idle_warn",  32'(warn),  32'd0);
        chk("arst_idle_tempo", 32'(TEMPO), 32'd0);
        E = 1'b1;
        push(0, 1, 0, 1);
        step(1);
        chk("arst_run_warn", 32'(warn),     32'd1);
        chk("arst_run_wait", 32'(sb.size()), 32'd1);
        step(1);
        chk("arst_drain", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
